spi_clk_gen: RTL and testbench

SPI_CLK_GEN -- requirements
Module: spi_clk_gen

---
 rtl/spi_clk_gen.sv | 148 ++++++++++++++
 tb/tb_spi_clk_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_clk_gen.sv
// SPI serial clock generator: programmable SCK divider, CPOL/CPHA strobes.
// Define SPI_CLK_GEN_BITCNT_EN to end transfers after nbits SCK cycles.
module spi_clk_gen #(
  parameter int DIV_WIDTH = 8,
  parameter int CNT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic [CNT_WIDTH-1:0] nbits,
  output logic                 sck,
  output logic                 lead_edge,
  output logic                 trail_edge,
  output logic                 sample,
  output logic                 shift,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] dcnt_q, dcnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 cpol_q, cpol_d;
  logic                 cpha_q, cpha_d;
  logic                 sck_q, sck_d;
  logic                 lead_q, lead_d;
  logic                 trail_q, trail_d;
  logic                 fin;

`ifdef SPI_CLK_GEN_BITCNT_EN
  logic [CNT_WIDTH-1:0] ecnt_q, ecnt_d;
  logic [CNT_WIDTH-1:0] nb_q, nb_d;
  logic                 done_q, done_d;

  assign fin  = done_q;
  assign done = done_q;
`else
  logic unused_nbits;

  assign unused_nbits = ^nbits;
  assign fin  = 1'b0;
  assign done = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    div_d   = div_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    sck_d   = sck_q;
    lead_d  = 1'b0;
    trail_d = 1'b0;
`ifdef SPI_CLK_GEN_BITCNT_EN
    ecnt_d  = ecnt_q;
    nb_d    = nb_q;
    done_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        sck_d  = cpol;
        dcnt_d = '0;
`ifdef SPI_CLK_GEN_BITCNT_EN
        ecnt_d = '0;
`endif
        if (start && !stop) begin
          state_d = RUN;
          div_d   = div;
          cpol_d  = cpol;
          cpha_d  = cpha;
`ifdef SPI_CLK_GEN_BITCNT_EN
          nb_d    = nbits;
`endif
        end
      end
      RUN: begin
        // abort and post-completion both park SCK at idle level
        if (stop || fin) begin
          state_d = IDLE;
          sck_d   = cpol_q;
          dcnt_d  = '0;
`ifdef SPI_CLK_GEN_BITCNT_EN
          ecnt_d  = '0;
`endif
        end else if (dcnt_q == div_q) begin
          dcnt_d  = '0;
          sck_d   = ~sck_q;
          lead_d  = (sck_q == cpol_q);
          trail_d = (sck_q != cpol_q);
`ifdef SPI_CLK_GEN_BITCNT_EN
          if (trail_d) begin
            ecnt_d = ecnt_q + 1'b1;
            done_d = (ecnt_d == nb_q);
          end
`endif
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
      div_q   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      sck_q   <= 1'b0;
      lead_q  <= 1'b0;
      trail_q <= 1'b0;
`ifdef SPI_CLK_GEN_BITCNT_EN
      ecnt_q  <= '0;
      nb_q    <= '0;
      done_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      div_q   <= div_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      sck_q   <= sck_d;
      lead_q  <= lead_d;
      trail_q <= trail_d;
`ifdef SPI_CLK_GEN_BITCNT_EN
      ecnt_q  <= ecnt_d;
      nb_q    <= nb_d;
      done_q  <= done_d;
`endif
    end
  end

  assign sck        = sck_q;
  assign lead_edge  = lead_q;
  assign trail_edge = trail_q;
  assign sample     = cpha_q ? trail_q : lead_q;
  assign shift      = cpha_q ? lead_q : trail_q;
  assign busy       = (state_q == RUN);

endmodule

// File: tb/tb_spi_clk_gen.sv
// Self-checking bench for spi_clk_gen: closed-form timing model,
// directed scenarios and randomized traffic.
module tb_spi_clk_gen;

  localparam int DW = 8;
  localparam int CW = 5;
`ifdef SPI_CLK_GEN_BITCNT_EN
  localparam bit BITCNT = 1'b1;
`else
  localparam bit BITCNT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [DW-1:0] div = '0;
  logic          cpol = 1'b0;
  logic          cpha = 1'b0;
  logic [CW-1:0] nbits = '0;
  logic          sck, lead_edge, trail_edge;
  logic          sample, shift, busy, done;

  spi_clk_gen #(.DIV_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .div(div), .cpol(cpol), .cpha(cpha), .nbits(nbits),
    .sck(sck), .lead_edge(lead_edge), .trail_edge(trail_edge),
    .sample(sample), .shift(shift), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  bit m_run = 1'b0;
  int t0, mh, mN;
  bit mcpol, mcpha;
  logic e_sck, e_busy, e_lead, e_trail, e_done;

  int c_lead, c_trail, c_samp, c_samp_low, c_done, done_cyc;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, got, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, got, exp);
    end
  endtask

  // Closed form: toggle k happens k*(div+1) cycles after the start edge
  task automatic model();
    int n, k;
    cyc++;
    e_lead = 1'b0;
    e_trail = 1'b0;
    e_done = 1'b0;
    if (!rst) begin
      m_run = 1'b0;
      e_sck = 1'b0;
    end else if (!m_run) begin
      e_sck = cpol;
      if (start && !stop) begin
        m_run = 1'b1;
        t0 = cyc;
        mh = int'(div) + 1;
        mcpol = cpol;
        mcpha = cpha;
        mN = (nbits == 0) ? (1 << CW) : int'(nbits);
      end
    end else begin
      n = cyc - t0;
      if (stop || (BITCNT && n > 2 * mN * mh)) begin
        m_run = 1'b0;
        e_sck = mcpol;
      end else begin
        k = n / mh;
        e_sck = mcpol ^ k[0];
        if (n % mh == 0) begin
          e_lead = k[0];
          e_trail = !k[0];
          e_done = BITCNT && !k[0] && (k == 2 * mN);
        end
      end
    end
    e_busy = m_run;
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    chk1("sck", sck, e_sck);
    chk1("busy", busy, e_busy);
    chk1("lead", lead_edge, e_lead);
    chk1("trail", trail_edge, e_trail);
    chk1("sample", sample, mcpha ? e_trail : e_lead);
    chk1("shift", shift, mcpha ? e_lead : e_trail);
    chk1("done", done, e_done);
    c_lead += int'(lead_edge);
    c_trail += int'(trail_edge);
    c_samp += int'(sample);
    if (sample && !sck) c_samp_low++;
    if (done) begin
      c_done++;
      done_cyc = cyc;
    end
  endtask

  task automatic clr();
    c_lead = 0;
    c_trail = 0;
    c_samp = 0;
    c_samp_low = 0;
    c_done = 0;
    done_cyc = -1;
  endtask

  task automatic go(input int d, input bit pol, input bit pha,
                    input int nb);
    div = DW'(d);
    cpol = pol;
    cpha = pha;
    nbits = CW'(nb);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic abort();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    clr();
    repeat (3) step();
    chk("rst_sck", int'(sck), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b1;
    step();

    // div=1 cpol=0 cpha=0 nbits=8
    clr();
    go(1, 0, 0, 8);
    chk("r31_busy_on", int'(busy), 1);
    repeat (32) step();
    chk("r31_lead", c_lead, 8);
    chk("r31_trail", c_trail, 8);
    chk("r31_samp", c_samp, 8);
    if (BITCNT) begin
      chk("r31_done_at", done_cyc - t0, 32);
      step();
      chk("r31_busy_off", int'(busy), 0);
      chk("r31_sck", int'(sck), 0);
    end else begin
      chk("r31_nodone", c_done, 0);
      abort();
    end
    step();

    // div=0 cpol=1 cpha=1 nbits=0
    clr();
    go(0, 1, 1, 0);
    repeat (64) step();
    chk("r32_samp", c_samp, 32);
    chk("r32_samp_low", c_samp_low, 0);
    if (BITCNT) begin
      chk("r32_done_at", done_cyc - t0, 64);
      step();
      chk("r32_sck", int'(sck), 1);
    end else begin
      abort();
    end
    step();

    // abort at n=10, then immediate restart
    clr();
    go(3, 1, 0, 5);
    repeat (9) step();
    abort();
    chk("r33_busy", int'(busy), 0);
    chk("r33_sck", int'(sck), 1);
    go(3, 0, 0, 5);
    chk("r33_restart", int'(busy), 1);
    chk("r33_nodone", c_done, 0);
    repeat (5) step();
    abort();
    step();

    // start+stop in IDLE blocked; start with div=7 during RUN ignored
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    chk("r34_blocked", int'(busy), 0);
    clr();
    go(1, 0, 0, 0);
    div = 8'd7;
    start = 1'b1;
    repeat (6) step();
    start = 1'b0;
    repeat (10) step();
    chk("r34_lead", c_lead, 4);
    abort();
    step();

    // reset while sck high
    go(2, 0, 0, 0);
    repeat (4) step();
    chk("r35_sck_hi", int'(sck), 1);
    rst = 1'b0;
    step();
    chk("r35_sck", int'(sck), 0);
    chk("r35_busy", int'(busy), 0);
    rst = 1'b1;
    cpol = 1'b1;
    step();
    chk("r35_track1", int'(sck), 1);
    cpol = 1'b0;
    step();
    chk("r35_track0", int'(sck), 0);

    // div=2 nbits=4
    clr();
    go(2, 0, 0, 4);
    repeat (40) step();
    if (BITCNT) begin
      chk("r36_done_at", done_cyc - t0, 24);
    end else begin
      chk("r36_nodone", c_done, 0);
      chk("r36_busy", int'(busy), 1);
      chk("r36_edges", c_lead + c_trail, 13);
      abort();
    end
    step();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom % 4) == 0;
      stop = ($urandom % 80) == 0;
      rst = ($urandom % 500) != 0;
      div = DW'($urandom % 5);
      cpol = 1'($urandom);
      cpha = 1'($urandom);
      nbits = CW'($urandom % 8);
      step();
    end
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    abort();
    chk("final_idle", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
